dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter_pkg.sv | 17 +
 rtl/dram_arbiter_rr_arb2.sv | 21 ++
 rtl/dram_arbiter.sv | 136 +++++++++++++
 tb/tb_dram_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the DRAM arbiter: FSM states, requester (owner) codes and
// the width of the access-latency counter.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  // Owner codes double as bit indices into the request/grant vectors.
  localparam logic OwnerCpu = 1'b0;
  localparam logic OwnerExt = 1'b1;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone requester wins; on contention the requester
// that did not win last time is granted. Grant is one-hot, indexed by owner code.
module rr_arb2
  import dram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OwnerExt) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one fixed-latency RAM port between the CPU MEM stage and an external
// requester. Each access runs IDLE -> ACCESS (LAT cycles) -> RESP.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       ext_rdata_q, ext_rdata_d;
  logic [1:0]        grant;

  rr_arb2 u_rr_arb2 (
    .req        ({ext_req, cpu_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;

    case (state_q)
      StIdle: begin
        if (|grant) begin
          owner_d      = grant[OwnerExt] ? OwnerExt : OwnerCpu;
          last_grant_d = owner_d;
          mem_en_d     = 1'b1;
          mem_we_d     = grant[OwnerExt] ? ext_we    : cpu_we;
          mem_addr_d   = grant[OwnerExt] ? ext_addr  : cpu_addr;
          mem_wdata_d  = grant[OwnerExt] ? ext_wdata : cpu_wdata;
          cnt_d        = CntInit;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Capture even on writes or a flushed CPU access; the RAM port must still
          // see a complete access.
          if (owner_q == OwnerExt) begin
            ext_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnerCpu;
      last_grant_q <= OwnerExt;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // Stall drops as soon as the CPU withdraws its request, so a flush never waits.
  assign cpu_stall = cpu_req & ~((state_q == StResp) && (owner_q == OwnerCpu));
  assign ext_ack   = (state_q == StResp) && (owner_q == OwnerExt);

  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter (LAT=2): scenario tasks plus a response scoreboard fed by
// expectations queued when each scenario drives its requests.
module tb_dram_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int ncheck = 0;
  int nbad   = 0;
  int t      = 0;
  int acc_cnt = 0;

  logic [31:0] ram [64];

  typedef struct packed {
    logic        is_ext;
    logic        chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  dram_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM model: read data is only valid in the last cycle of an access.
  always @(posedge clk) begin
    acc_cnt <= mem_en ? acc_cnt + 1 : 0;
    t = t + 1;
  end

  always @(negedge clk) begin
    if (mem_en && mem_we && acc_cnt == LAT - 1) ram[mem_addr[7:2]] = mem_wdata;
  end

  assign mem_rdata = (mem_en && acc_cnt == LAT - 1) ? ram[mem_addr[7:2]] : 32'hBAD0_BAD0;

  // Scoreboard: every visible response must match the oldest expectation.
  always @(negedge clk) begin
    if (cpu_req && !cpu_stall) begin
      ncheck++;
      if (sbq.size() == 0) begin
        nbad++;
        $display("FAIL cpu_resp: got response cyc=%0d data=%h, want none", t, cpu_rdata);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.is_ext || mon_e.cyc != t || (mon_e.chk && cpu_rdata !== mon_e.data)) begin
          nbad++;
          $display("FAIL cpu_resp: got cpu cyc=%0d data=%h, want ext=%0b cyc=%0d data=%h",
                   t, cpu_rdata, mon_e.is_ext, mon_e.cyc, mon_e.data);
        end
      end
    end
    if (ext_ack) begin
      ncheck++;
      if (sbq.size() == 0) begin
        nbad++;
        $display("FAIL ext_ack: got ack cyc=%0d data=%h, want none", t, ext_rdata);
      end else begin
        mon_e = sbq.pop_front();
        if (!mon_e.is_ext || mon_e.cyc != t || (mon_e.chk && ext_rdata !== mon_e.data)) begin
          nbad++;
          $display("FAIL ext_ack: got ext cyc=%0d data=%h, want ext=%0b cyc=%0d data=%h",
                   t, ext_rdata, mon_e.is_ext, mon_e.cyc, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic is_ext, input logic chk, input logic [31:0] data,
                          input int cyc);
    exp_t e;
    e.is_ext = is_ext;
    e.chk    = chk;
    e.data   = data;
    e.cyc    = cyc;
    sbq.push_back(e);
  endtask

  task automatic sb_drained(input string name);
    ncheck++;
    if (sbq.size() != 0) begin
      nbad++;
      $display("FAIL %s_drain: got %0d pending responses, want 0", name, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    ncheck++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      nbad++; $display("FAIL reset_en: got en=%b we=%b, want 0 0", mem_en, mem_we);
    end
    ncheck++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      nbad++; $display("FAIL reset_addr: got %h %h, want 0 0", mem_addr, mem_wdata);
    end
    ncheck++;
    if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
      nbad++; $display("FAIL reset_rdata: got %h %h, want 0 0", cpu_rdata, ext_rdata);
    end
    ncheck++;
    if (ext_ack !== 1'b0 || cpu_stall !== 1'b0) begin
      nbad++; $display("FAIL reset_ack: got ack=%b stall=%b, want 0 0", ext_ack, cpu_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_load();
    t = 0;
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, 3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        ncheck++;
        if (cpu_stall !== 1'(k < 3)) begin
          nbad++; $display("FAIL load_stall: cyc %0d got %b, want %b", k, cpu_stall, k < 3);
        end
      end
      if (k == 1 || k == 2) begin
        ncheck++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin
          nbad++; $display("FAIL load_mem: cyc %0d got en=%b addr=%h, want 1 00000010",
                           k, mem_en, mem_addr);
        end
      end
      @(posedge clk); #1;
      if (k == 3) cpu_req = 1'b0;
    end
    sb_drained("load");
  endtask

  task automatic test_ext_write();
    int we_cycles = 0;
    t = 0;
    push_exp(1'b1, 1'b0, 32'h0, 3);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h1234_5678;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_we) we_cycles++;
      if (k == 1 || k == 2) begin
        ncheck++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 ||
            mem_wdata !== 32'h1234_5678) begin
          nbad++; $display("FAIL wr_mem: cyc %0d got en=%b we=%b addr=%h wd=%h, want 1 1 20 12345678",
                           k, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (k == 3) begin
        ncheck++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
          nbad++; $display("FAIL wr_release: got en=%b we=%b, want 0 0", mem_en, mem_we);
        end
      end
      @(posedge clk); #1;
      if (k == 3) begin
        ext_req = 1'b0; ext_we = 1'b0;
      end
    end
    ncheck++;
    if (we_cycles != LAT) begin
      nbad++; $display("FAIL wr_len: got %0d write cycles, want %0d", we_cycles, LAT);
    end
    ncheck++;
    if (ram[8] !== 32'h1234_5678) begin
      nbad++; $display("FAIL wr_data: got ram %h, want 12345678", ram[8]);
    end
    sb_drained("wr");
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h30; exp_addr[1] = 32'h40; exp_addr[2] = 32'h34; exp_addr[3] = 32'h44;
    do_reset();
    t = 0;
    push_exp(1'b0, 1'b1, ram[12], 3);
    push_exp(1'b1, 1'b1, ram[16], 7);
    push_exp(1'b0, 1'b1, ram[13], 11);
    push_exp(1'b1, 1'b1, ram[17], 15);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k % 4 == 1) begin
        ncheck++;
        if (mem_en !== 1'b1 || mem_addr !== exp_addr[k / 4]) begin
          nbad++; $display("FAIL rr_order: cyc %0d got en=%b addr=%h, want 1 %h",
                           k, mem_en, mem_addr, exp_addr[k / 4]);
        end
      end
      @(posedge clk); #1;
      if (k == 3)  cpu_addr = 32'h34;
      if (k == 7)  ext_addr = 32'h44;
      if (k == 11) cpu_req = 1'b0;
      if (k == 15) ext_req = 1'b0;
    end
    sb_drained("rr");
  endtask

  task automatic test_reset_mid();
    t = 0;
    push_exp(1'b1, 1'b1, ram[16], 5);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        ncheck++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
          nbad++; $display("FAIL abort_mem: got en=%b we=%b addr=%h wd=%h, want 0 0 0 0",
                           mem_en, mem_we, mem_addr, mem_wdata);
        end
        ncheck++;
        if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0 || ext_ack !== 1'b0) begin
          nbad++; $display("FAIL abort_out: got cpu=%h ext=%h ack=%b, want 0 0 0",
                           cpu_rdata, ext_rdata, ext_ack);
        end
      end
      @(posedge clk); #1;
      if (k == 0) rst = 1'b1;
      if (k == 1) rst = 1'b0;
      if (k == 5) ext_req = 1'b0;
    end
    sb_drained("abort");
  endtask

  task automatic test_flush();
    t = 0;
    push_exp(1'b0, 1'b1, ram[21], 7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ncheck++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h50) begin
          nbad++; $display("FAIL flush_c1: got stall=%b en=%b addr=%h, want 0 1 00000050",
                           cpu_stall, mem_en, mem_addr);
        end
      end
      if (k == 2) begin
        ncheck++;
        if (mem_en !== 1'b1) begin
          nbad++; $display("FAIL flush_c2: got en=%b, want 1", mem_en);
        end
      end
      if (k == 3) begin
        ncheck++;
        if (mem_en !== 1'b0 || cpu_rdata !== ram[20]) begin
          nbad++; $display("FAIL flush_cap: got en=%b rdata=%h, want 0 %h",
                           mem_en, cpu_rdata, ram[20]);
        end
      end
      if (k == 5) begin
        ncheck++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h54) begin
          nbad++; $display("FAIL flush_next: got en=%b addr=%h, want 1 00000054", mem_en, mem_addr);
        end
      end
      if (k == 8) begin
        ncheck++;
        if (cpu_rdata !== ram[21] || ext_rdata !== ram[16]) begin
          nbad++; $display("FAIL hold_rdata: got cpu=%h ext=%h, want %h %h",
                           cpu_rdata, ext_rdata, ram[21], ram[16]);
        end
      end
      @(posedge clk); #1;
      if (k == 0) cpu_req = 1'b0;
      if (k == 3) begin
        cpu_req = 1'b1; cpu_addr = 32'h54;
      end
      if (k == 7) cpu_req = 1'b0;
    end
    sb_drained("flush");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hA500_0000 + 32'(i * 17);
    ram[4] = 32'hDEAD_BEEF;
    test_reset();
    test_cpu_load();
    test_ext_write();
    test_contention();
    test_reset_mid();
    test_flush();
    $display("test done: total=%0d bad=%0d", ncheck, nbad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, want finish");
    $fatal(1);
  end

endmodule
